// File: rtl/shift_chain_pkg.sv
// Shared types and constants for the shift-chain serializer.
package shift_chain_pkg;

  localparam int WORD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH up-counter with synchronous clear and terminal-count flag.
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment, wrap after the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST_VAL) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/shift_chain_ctrl.sv
// Serializes WIDTH-bit words MSB first into a shift chain, with an optional
// idle gap after each word, abort support and a wrapping word counter.
module shift_chain_ctrl
  import shift_chain_pkg::*;
#(
  parameter int WIDTH      = 100,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  abort_i,
  output logic                  ser_data_o,
  output logic                  ser_en_o,
  output logic                  frame_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [WORD_CNT_W-1:0] word_cnt_o
);

  localparam int CNT_W = $clog2(WIDTH);
  // Gap counter still needs a legal size when no gap is configured.
  localparam int GAP_N = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int GAP_W = (GAP_N > 1) ? $clog2(GAP_N) : 1;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        hold_q, hold_d;
  logic [WORD_CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic                    frame_q, frame_d;
  logic                    bit_clr_s, bit_inc_s, bit_last_s;
  logic                    gap_clr_s, gap_inc_s, gap_last_s;

  shift_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bit_clr_s),
    .inc   (bit_inc_s),
    .last  (bit_last_s)
  );

  shift_bit_counter #(.WIDTH(GAP_N), .CNT_W(GAP_W)) u_gap_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (gap_clr_s),
    .inc   (gap_inc_s),
    .last  (gap_last_s)
  );

  // Next-state, datapath updates and decoded outputs.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    word_cnt_d = word_cnt_q;
    frame_d    = 1'b0;
    bit_clr_s  = 1'b0;
    bit_inc_s  = 1'b0;
    gap_clr_s  = 1'b0;
    gap_inc_s  = 1'b0;
    in_ready_o = 1'b0;
    ser_en_o   = 1'b0;
    ser_data_o = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = !abort_i;
        if (in_valid_i && !abort_i) begin
          hold_d    = in_data_i;
          bit_clr_s = 1'b1;
          frame_d   = 1'b1;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        ser_en_o   = 1'b1;
        ser_data_o = hold_q[WIDTH-1];
        done_o     = bit_last_s;
        hold_d     = {hold_q[WIDTH-2:0], 1'b0};
        bit_inc_s  = 1'b1;
        // Abort beats completion: a word aborted on its last bit is not counted.
        if (abort_i) begin
          state_d = IDLE;
        end else if (bit_last_s) begin
          word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
          gap_clr_s  = 1'b1;
          state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          state_d = SHIFT;
        end
      end
      GAP: begin
        gap_inc_s = 1'b1;
        if (abort_i || gap_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      word_cnt_q <= '0;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      word_cnt_q <= word_cnt_d;
      frame_q    <= frame_d;
    end
  end

  // frame_q is set only by a transfer, so it marks exactly the first SHIFT cycle.
  assign frame_o    = frame_q;
  assign busy_o     = (state_q != IDLE);
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Scoreboard bench: WIDTH=8 with GAP_CYCLES=2 (dut1) and GAP_CYCLES=0 (dut0).
module tb_shift_chain_ctrl;

  typedef struct {
    int   cyc;
    logic d;
    logic f;
    logic dn;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          n_tests;
  int          n_fail;
  exp_t        q1[$];
  exp_t        q0[$];
  exp_t        e1;
  exp_t        e0;

  logic [7:0]  in_data1, in_data0;
  logic        in_valid1, in_valid0, abort1, abort0;
  logic        in_ready1, ser_data1, ser_en1, frame1, done1, busy1;
  logic        in_ready0, ser_data0, ser_en0, frame0, done0, busy0;
  logic [15:0] word_cnt1, word_cnt0;

  shift_chain_ctrl #(.WIDTH(8), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .reset(rst_n), .in_data_i(in_data1), .in_valid_i(in_valid1),
    .in_ready_o(in_ready1), .abort_i(abort1), .ser_data_o(ser_data1),
    .ser_en_o(ser_en1), .frame_o(frame1), .done_o(done1), .busy_o(busy1),
    .word_cnt_o(word_cnt1)
  );

  shift_chain_ctrl #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .in_data_i(in_data0), .in_valid_i(in_valid0),
    .in_ready_o(in_ready0), .abort_i(abort0), .ser_data_o(ser_data0),
    .ser_en_o(ser_en0), .frame_o(frame0), .done_o(done0), .busy_o(busy0),
    .word_cnt_o(word_cnt0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Queue the serial bits a word should produce, starting in cycle 'start'.
  task automatic push_word(input bit sel, input logic [7:0] w, input int start, input int nbits);
    exp_t x;
    for (int k = 0; k < nbits; k++) begin
      x.cyc = start + k;
      x.d   = w[7-k];
      x.f   = (k == 0);
      x.dn  = (k == 7);
      if (sel) q1.push_back(x);
      else     q0.push_back(x);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for dut1: every enabled bit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ser_en1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb1_unexpected_bit: got ser_en=1 expected no bit (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        check("sb1_cycle", 32'(cyc), 32'(e1.cyc));
        check("sb1_data", 32'(ser_data1), 32'(e1.d));
        check("sb1_frame", 32'(frame1), 32'(e1.f));
        check("sb1_done", 32'(done1), 32'(e1.dn));
      end
    end else begin
      check("sb1_quiet_outputs", 32'({ser_data1, frame1, done1}), 32'(0));
    end
  end

  // Monitor for dut0.
  always @(negedge clk) begin
    if (ser_en0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb0_unexpected_bit: got ser_en=1 expected no bit (cycle %0d)", cyc);
      end else begin
        e0 = q0.pop_front();
        check("sb0_cycle", 32'(cyc), 32'(e0.cyc));
        check("sb0_data", 32'(ser_data0), 32'(e0.d));
        check("sb0_frame", 32'(frame0), 32'(e0.f));
        check("sb0_done", 32'(done0), 32'(e0.dn));
      end
    end else begin
      check("sb0_quiet_outputs", 32'({ser_data0, frame0, done0}), 32'(0));
    end
  end

  initial begin
    int c;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_data1  = 8'h00; in_valid1 = 1'b0; abort1 = 1'b0;
    in_data0  = 8'h00; in_valid0 = 1'b0; abort0 = 1'b0;

    // Reset values
    tick(2);
    check("rst_ready", 32'(in_ready1), 32'(1));
    check("rst_busy", 32'(busy1), 32'(0));
    check("rst_ser", 32'({ser_en1, ser_data1, frame1, done1}), 32'(0));
    check("rst_wcnt", 32'(word_cnt1), 32'(0));
    check("rst_ready0", 32'(in_ready0), 32'(1));
    rst_n = 1'b1;

    // 0xA5: bits in cycles c+1..c+8, gap c+9..c+10, ready at c+11
    c = cyc; in_data1 = 8'hA5; in_valid1 = 1'b1;
    push_word(1'b1, 8'hA5, c + 1, 8);
    tick(1);
    in_valid1 = 1'b0; in_data1 = 8'h5A;
    check("a5_busy", 32'(busy1), 32'(1));
    check("a5_ready_in_shift", 32'(in_ready1), 32'(0));
    tick(8);
    check("a5_gap1_en", 32'(ser_en1), 32'(0));
    check("a5_gap1_busy", 32'(busy1), 32'(1));
    check("a5_gap1_ready", 32'(in_ready1), 32'(0));
    check("a5_wcnt", 32'(word_cnt1), 32'(1));
    tick(1);
    check("a5_gap2_busy", 32'(busy1), 32'(1));
    tick(1);
    check("a5_idle_ready", 32'(in_ready1), 32'(1));
    check("a5_idle_busy", 32'(busy1), 32'(0));

    // 0xFF then 0x00 with valid held; data changed mid-word is ignored
    c = cyc; in_data1 = 8'hFF; in_valid1 = 1'b1;
    push_word(1'b1, 8'hFF, c + 1, 8);
    push_word(1'b1, 8'h00, c + 12, 8);
    tick(1);
    in_data1 = 8'h00;
    tick(11);
    in_valid1 = 1'b0; in_data1 = 8'hFF;
    tick(10);
    check("b2b_wcnt", 32'(word_cnt1), 32'(3));
    check("b2b_ready", 32'(in_ready1), 32'(1));

    // Abort in cycle 4 of 0xC3: only bits 1,1,0,0 appear, no done, no count
    c = cyc; in_data1 = 8'hC3; in_valid1 = 1'b1;
    push_word(1'b1, 8'hC3, c + 1, 4);
    tick(1);
    in_valid1 = 1'b0;
    tick(3);
    abort1 = 1'b1;
    tick(1);
    abort1 = 1'b0;
    check("abort_busy", 32'(busy1), 32'(0));
    check("abort_wcnt", 32'(word_cnt1), 32'(3));

    // Abort in IDLE blocks the transfer
    abort1 = 1'b1; in_valid1 = 1'b1; in_data1 = 8'h99;
    #1;
    check("idle_abort_ready", 32'(in_ready1), 32'(0));
    tick(1);
    check("idle_abort_no_xfer", 32'(busy1), 32'(0));
    abort1 = 1'b0; in_data1 = 8'h96;
    c = cyc;
    push_word(1'b1, 8'h96, c + 1, 8);
    tick(1);
    in_valid1 = 1'b0;
    tick(10);
    check("post_abort_wcnt", 32'(word_cnt1), 32'(4));

    // Abort coincident with the last bit: done still seen, no count, no gap
    c = cyc; in_data1 = 8'hE7; in_valid1 = 1'b1;
    push_word(1'b1, 8'hE7, c + 1, 8);
    tick(1);
    in_valid1 = 1'b0;
    tick(7);
    abort1 = 1'b1;
    tick(1);
    abort1 = 1'b0;
    check("last_abort_busy", 32'(busy1), 32'(0));
    check("last_abort_wcnt", 32'(word_cnt1), 32'(4));

    // Reset in cycle 5 of a word, then 0x3C on the first edge after release
    c = cyc; in_data1 = 8'h5B; in_valid1 = 1'b1;
    push_word(1'b1, 8'h5B, c + 1, 4);
    tick(1);
    in_valid1 = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("midrst_ser_en", 32'(ser_en1), 32'(0));
    check("midrst_ser_data", 32'(ser_data1), 32'(0));
    check("midrst_frame_done", 32'({frame1, done1}), 32'(0));
    check("midrst_busy", 32'(busy1), 32'(0));
    check("midrst_ready", 32'(in_ready1), 32'(1));
    check("midrst_wcnt", 32'(word_cnt1), 32'(0));
    tick(1);
    rst_n = 1'b1; in_data1 = 8'h3C; in_valid1 = 1'b1;
    c = cyc;
    push_word(1'b1, 8'h3C, c + 1, 8);
    tick(1);
    in_valid1 = 1'b0;
    tick(10);
    check("postrst_wcnt", 32'(word_cnt1), 32'(1));
    check("postrst_busy", 32'(busy1), 32'(0));

    // GAP_CYCLES=0: two 0x81 words separated by exactly one IDLE cycle
    c = cyc; in_data0 = 8'h81; in_valid0 = 1'b1;
    push_word(1'b0, 8'h81, c + 1, 8);
    push_word(1'b0, 8'h81, c + 10, 8);
    tick(9);
    check("gap0_idle_en", 32'(ser_en0), 32'(0));
    check("gap0_idle_ready", 32'(in_ready0), 32'(1));
    check("gap0_idle_wcnt", 32'(word_cnt0), 32'(1));
    tick(1);
    in_valid0 = 1'b0;
    tick(8);
    check("gap0_wcnt", 32'(word_cnt0), 32'(2));
    check("gap0_busy", 32'(busy0), 32'(0));

    // Word counter wrap 0xFFFF -> 0x0000
    force dut1.word_cnt_q = 16'hFFFF;
    tick(1);
    release dut1.word_cnt_q;
    #1;
    check("wrap_preload", 32'(word_cnt1), 32'(16'hFFFF));
    c = cyc; in_data1 = 8'h69; in_valid1 = 1'b1;
    push_word(1'b1, 8'h69, c + 1, 8);
    tick(1);
    in_valid1 = 1'b0;
    tick(10);
    check("wrap_wcnt", 32'(word_cnt1), 32'(0));

    tick(2);
    check("sb1_drained", 32'(q1.size()), 32'(0));
    check("sb0_drained", 32'(q0.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_chain_ctrl.md
SHIFT_CHAIN_CTRL -- requirements
Module: shift_chain_ctrl

Interface
REQ-001 Parameter WIDTH, default 100: bits per serialized word, WIDTH >= 2.
REQ-002 Parameter GAP_CYCLES, default 0: idle cycles inserted after each word, range 0..255.
REQ-003 Localparam CNT_W = $clog2(WIDTH): bit-counter width, derived and not overridable.
REQ-004 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 in_data_i  input  WIDTH  parallel word to serialize.
REQ-007 in_valid_i  input  1  in_data_i is valid.
REQ-008 in_ready_o  output  1  controller accepts a word this cycle.
REQ-009 abort_i  input  1  synchronous abort of the current word.
REQ-010 ser_data_o  output  1  serial bit driven into the shift chain.
REQ-011 ser_en_o  output  1  ser_data_o is valid and the chain shifts this cycle.
REQ-012 frame_o  output  1  high with the first bit of a word.
REQ-013 done_o  output  1  one-cycle pulse with the last bit of a word.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 word_cnt_o  output  16  count of fully serialized words.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and GAP.
REQ-017 in_ready_o SHALL be 1 only in IDLE; a transfer occurs when in_valid_i && in_ready_o at a rising edge.
REQ-018 On transfer, in_data_i SHALL be latched into a WIDTH-bit holding register, the bit counter cleared, and the state set to SHIFT.
REQ-019 Latency: the first bit SHALL appear on ser_data_o in the cycle immediately after the transfer edge.
REQ-020 In SHIFT, outputs SHALL be: ser_en_o=1, ser_data_o = holding register MSB (MSB first); each edge shifts the register left by one and increments the counter.
REQ-021 frame_o SHALL be 1 in SHIFT when the counter is 0; done_o SHALL be 1 in SHIFT when the counter is WIDTH-1.
REQ-022 After the counter = WIDTH-1 edge, word_cnt_o SHALL increment (wrapping 0xFFFF -> 0x0000) and the state SHALL move to GAP if GAP_CYCLES > 0, otherwise to IDLE.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles with ser_en_o=0 and ser_data_o=0, then return to IDLE.
REQ-024 Outside SHIFT, ser_en_o, ser_data_o, frame_o and done_o SHALL be 0.
REQ-025 abort_i in SHIFT or GAP SHALL force IDLE at the next edge with no done_o and no word_cnt_o increment; outputs in the abort cycle follow the normal rules.
REQ-026 abort_i coincident with the last bit (counter = WIDTH-1) SHALL take priority: done_o is still driven combinationally that cycle, but word_cnt_o does not increment.
REQ-027 abort_i in IDLE SHALL block a transfer in that cycle, so in_ready_o = !abort_i in IDLE.
REQ-028 in_valid_i SHALL be ignored outside IDLE, and in_data_i changes outside IDLE SHALL not affect the word in flight.

Reset
REQ-029 While reset=0, state SHALL be IDLE; holding register, bit counter, gap counter and word_cnt_o SHALL be 0.
REQ-030 Output reset values: in_ready_o=1, busy_o=0, ser_en_o=0, ser_data_o=0, frame_o=0, done_o=0, word_cnt_o=0.
REQ-031 Reset asserted mid-word SHALL discard the word immediately (asynchronously); after release the block SHALL accept a new word on the first edge.

Structure
REQ-032 A package shift_chain_pkg SHALL hold the state enum typedef (IDLE/SHIFT/GAP) and the 16-bit word-count width constant.
REQ-033 The bit counter with its terminal-count flag SHALL be one sub-module, shift_bit_counter (parameter WIDTH, inputs clr/inc, output last), reused for the gap counter.
REQ-034 The block SHALL have no combinational path from in_data_i to any output.

Verification (WIDTH=8, GAP_CYCLES=2 unless stated)
REQ-035 Send 0xA5 at edge 0 -> ser_data_o = 1,0,1,0,0,1,0,1 in cycles 1..8; frame_o in cycle 1; done_o in cycle 8; GAP in cycles 9-10; in_ready_o=1 in cycle 11; word_cnt_o=1.
REQ-036 Send 0xFF then 0x00 with in_valid_i held high -> second frame_o 11 cycles after the first; word_cnt_o=2.
REQ-037 GAP_CYCLES=0: send 0x81 back-to-back -> words separated by exactly one IDLE cycle; ser_en_o low only in that cycle.
REQ-038 Assert abort_i in cycle 4 of 0xC3 -> IDLE at the next edge; no done_o; word_cnt_o unchanged; next word serializes correctly.
REQ-039 Assert reset=0 in cycle 5 of a word -> all outputs go to reset values asynchronously; the first post-reset word 0x3C serializes intact.
REQ-040 Preload word_cnt_o to 0xFFFF by forcing it or running 65535 words, then send one word -> word_cnt_o=0x0000.
